// File: rtl/doctor_allocator.sv
// Doctor allocation engine: fixed-priority assignment of tagged patients to capable free doctors.
// Define WAITQ_EN to build the QDEPTH-entry FIFO waiting queue; otherwise unservable requests are rejected.
module doctor_allocator #(
   parameter int NUM_DOC        = 4,
   parameter int QW             = 2,
   parameter logic [NUM_DOC*(2**QW)-1:0] CAP_MAP = 16'h8FE7,
   parameter int CONSULT_CYCLES = 15,
   parameter int TAG_W          = 4,
   parameter int QDEPTH         = 4,
   localparam int DW            = (NUM_DOC > 1) ? $clog2(NUM_DOC) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [QW-1:0]      req_query,
   input  logic [TAG_W-1:0]   req_tag,
   input  logic [NUM_DOC-1:0] release_doc,
   output logic               resp_valid,
   output logic [1:0]         resp_status,
   output logic [DW-1:0]      resp_doc,
   output logic [TAG_W-1:0]   resp_tag,
   output logic [NUM_DOC-1:0] busy,
   output logic [7:0]         reject_cnt
);
   // Handshake: a request transfers on a rising edge where req_valid && req_ready;
   // req_ready is derived from registered state only and never looks at req_valid.

   localparam int NQ = 2**QW;
   localparam int TW = $clog2(CONSULT_CYCLES + 1);
   localparam logic [TW-1:0] T_LOAD = TW'(CONSULT_CYCLES - 1);

   logic [NUM_DOC-1:0] busy_q, busy_d;
   logic [TW-1:0]      timer_q [NUM_DOC];
   logic [TW-1:0]      timer_d [NUM_DOC];
   logic               resp_valid_q, resp_valid_d;
   logic [1:0]         resp_status_q, resp_status_d;
   logic [DW-1:0]      resp_doc_q, resp_doc_d;
   logic [TAG_W-1:0]   resp_tag_q, resp_tag_d;
   logic [7:0]         reject_cnt_q, reject_cnt_d;

   logic [NUM_DOC-1:0] req_elig;
   logic               accept, alloc, rej, dispatch, q_empty;
   logic [DW-1:0]      alloc_doc;

   function automatic logic [NUM_DOC-1:0] elig_of(input logic [QW-1:0] q,
                                                  input logic [NUM_DOC-1:0] b);
      logic [NUM_DOC-1:0] e;
      for (int d = 0; d < NUM_DOC; d++) e[d] = CAP_MAP[d*NQ + int'(q)] && !b[d];
      return e;
   endfunction

   function automatic logic [DW-1:0] lowest(input logic [NUM_DOC-1:0] e);
      logic [DW-1:0] p;
      p = '0;
      for (int d = NUM_DOC - 1; d >= 0; d--) if (e[d]) p = DW'(d);
      return p;
   endfunction

`ifdef WAITQ_EN
   localparam int PW = $clog2(QDEPTH);
   logic [PW:0]        wr_q, wr_d, rd_q, rd_d;
   logic [QW-1:0]      qq_q [QDEPTH];
   logic [QW-1:0]      qq_d [QDEPTH];
   logic [TAG_W-1:0]   qt_q [QDEPTH];
   logic [TAG_W-1:0]   qt_d [QDEPTH];
   logic               q_full, enq;
   logic [NUM_DOC-1:0] head_elig;

   assign q_empty   = (wr_q == rd_q);
   assign q_full    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
   assign head_elig = elig_of(qq_q[rd_q[PW-1:0]], busy_q);
   // The head always wins the single allocation slot, so new requests wait that cycle.
   assign dispatch  = !q_empty && (|head_elig);
   assign req_ready = rst_n && !dispatch && !q_full;

   always_comb begin
      wr_d = wr_q + {{PW{1'b0}}, enq};
      rd_d = rd_q + {{PW{1'b0}}, dispatch};
      qq_d = qq_q;
      qt_d = qt_q;
      if (enq) begin
         qq_d[wr_q[PW-1:0]] = req_query;
         qt_d[wr_q[PW-1:0]] = req_tag;
      end
   end
`else
   assign q_empty   = 1'b1;
   assign dispatch  = 1'b0;
   assign req_ready = rst_n;
`endif

   assign req_elig = elig_of(req_query, busy_q);
   assign accept   = req_valid && req_ready;

   always_comb begin
      alloc         = 1'b0;
      alloc_doc     = '0;
      rej           = 1'b0;
`ifdef WAITQ_EN
      enq           = 1'b0;
`endif
      resp_valid_d  = 1'b0;
      resp_status_d = resp_status_q;
      resp_doc_d    = resp_doc_q;
      resp_tag_d    = resp_tag_q;
`ifdef WAITQ_EN
      if (dispatch) begin
         alloc         = 1'b1;
         alloc_doc     = lowest(head_elig);
         resp_valid_d  = 1'b1;
         resp_status_d = 2'b01;
         resp_doc_d    = alloc_doc;
         resp_tag_d    = qt_q[rd_q[PW-1:0]];
      end else
`endif
      if (accept) begin
         resp_valid_d = 1'b1;
         resp_tag_d   = req_tag;
         resp_doc_d   = '0;
         if (q_empty && (|req_elig)) begin
            alloc         = 1'b1;
            alloc_doc     = lowest(req_elig);
            resp_status_d = 2'b01;
            resp_doc_d    = alloc_doc;
         end else begin
`ifdef WAITQ_EN
            enq           = 1'b1;
            resp_status_d = 2'b10;
`else
            rej           = 1'b1;
            resp_status_d = 2'b11;
`endif
         end
      end
      reject_cnt_d = (rej && reject_cnt_q != 8'hFF) ? reject_cnt_q + 8'd1 : reject_cnt_q;

      // Allocation only ever targets a free doctor, so it cannot collide with a countdown.
      for (int d = 0; d < NUM_DOC; d++) begin
         busy_d[d]  = busy_q[d];
         timer_d[d] = timer_q[d];
         if (busy_q[d]) begin
            if (release_doc[d] || timer_q[d] == '0) begin
               busy_d[d]  = 1'b0;
               timer_d[d] = '0;
            end else begin
               timer_d[d] = timer_q[d] - TW'(1);
            end
         end else if (alloc && alloc_doc == DW'(d)) begin
            busy_d[d]  = 1'b1;
            timer_d[d] = T_LOAD;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q        <= '0;
         for (int d = 0; d < NUM_DOC; d++) timer_q[d] <= '0;
         resp_valid_q  <= 1'b0;
         resp_status_q <= '0;
         resp_doc_q    <= '0;
         resp_tag_q    <= '0;
         reject_cnt_q  <= '0;
`ifdef WAITQ_EN
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            qq_q[i] <= '0;
            qt_q[i] <= '0;
         end
`endif
      end else begin
         busy_q        <= busy_d;
         timer_q       <= timer_d;
         resp_valid_q  <= resp_valid_d;
         resp_status_q <= resp_status_d;
         resp_doc_q    <= resp_doc_d;
         resp_tag_q    <= resp_tag_d;
         reject_cnt_q  <= reject_cnt_d;
`ifdef WAITQ_EN
         wr_q <= wr_d;
         rd_q <= rd_d;
         qq_q <= qq_d;
         qt_q <= qt_d;
`endif
      end
   end

   assign resp_valid  = resp_valid_q;
   assign resp_status = resp_status_q;
   assign resp_doc    = resp_doc_q;
   assign resp_tag    = resp_tag_q;
   assign busy        = busy_q;
   assign reject_cnt  = reject_cnt_q;

endmodule

// File: tb/tb_doctor_allocator.sv
// Self-checking bench for doctor_allocator: directed vector table, hand sequences and random traffic
// compared against a countdown/queue model of the allocation rules (follows WAITQ_EN when defined).
module tb_doctor_allocator;
   localparam int NUM_DOC = 4;
   localparam int QW      = 2;
   localparam int NQ      = 4;
   localparam int TAG_W   = 4;
   localparam int QDEPTH  = 4;
   localparam int CC      = 15;
   localparam logic [15:0] CAP = 16'h8FE7;
`ifdef WAITQ_EN
   localparam logic [1:0] NOELIG_ST = 2'b10;
`else
   localparam logic [1:0] NOELIG_ST = 2'b11;
`endif

   logic               clk, rst_n, req_valid, req_ready, resp_valid;
   logic [QW-1:0]      req_query;
   logic [TAG_W-1:0]   req_tag, resp_tag;
   logic [NUM_DOC-1:0] release_doc, busy;
   logic [1:0]         resp_status;
   logic [1:0]         resp_doc;
   logic [7:0]         reject_cnt;

   doctor_allocator #(
      .NUM_DOC(NUM_DOC), .QW(QW), .CAP_MAP(CAP), .CONSULT_CYCLES(CC),
      .TAG_W(TAG_W), .QDEPTH(QDEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_query(req_query), .req_tag(req_tag), .release_doc(release_doc),
      .resp_valid(resp_valid), .resp_status(resp_status), .resp_doc(resp_doc),
      .resp_tag(resp_tag), .busy(busy), .reject_cnt(reject_cnt)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   typedef struct { int q; int t; } pat_t;
   pat_t wq[$];
   int   rem [NUM_DOC];     // cycles of consultation left; 0 = free
   int   m_rej;
   bit   e_valid;
   int   e_status, e_doc, e_tag;
   bit   last_rdy;

   function automatic int first_free(input int q);
      for (int d = 0; d < NUM_DOC; d++)
         if (CAP[d*NQ + q] && rem[d] == 0) return d;
      return -1;
   endfunction

   function automatic bit model_ready();
`ifdef WAITQ_EN
      if (wq.size() > 0 && first_free(wq[0].q) >= 0) return 1'b0;
      if (wq.size() == QDEPTH) return 1'b0;
`endif
      return 1'b1;
   endfunction

   function automatic int model_busy();
      int b = 0;
      for (int d = 0; d < NUM_DOC; d++) if (rem[d] > 0) b |= (1 << d);
      return b;
   endfunction

   task automatic model_reset();
      wq.delete();
      for (int d = 0; d < NUM_DOC; d++) rem[d] = 0;
      m_rej = 0;
      e_valid = 0;
   endtask

   task automatic model_step(input bit v, input int q, input int tag, input int rel, input bit rdy);
      int pick = -1;
      e_valid = 0;
      if (wq.size() > 0 && first_free(wq[0].q) >= 0) begin
         pick = first_free(wq[0].q);
         e_valid = 1; e_status = 1; e_doc = pick; e_tag = wq[0].t;
         void'(wq.pop_front());
      end else if (v && rdy) begin
         e_valid = 1; e_tag = tag; e_doc = 0;
         if (wq.size() == 0 && first_free(q) >= 0) begin
            pick = first_free(q);
            e_status = 1; e_doc = pick;
         end else begin
`ifdef WAITQ_EN
            wq.push_back('{q: q, t: tag});
            e_status = 2;
`else
            e_status = 3;
            if (m_rej < 255) m_rej++;
`endif
         end
      end
      for (int d = 0; d < NUM_DOC; d++)
         if (rem[d] > 0) rem[d] = rel[d] ? 0 : rem[d] - 1;
      if (pick >= 0) rem[pick] = CC;
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst_n = 1'b0; req_valid = 1'b0; req_query = '0; req_tag = '0; release_doc = '0;
      model_reset();
      #2;
      check("rst_ready", req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_status", resp_status, 0);
      check("rst_resp_doc", resp_doc, 0);
      check("rst_resp_tag", resp_tag, 0);
      check("rst_busy", busy, 0);
      check("rst_reject_cnt", reject_cnt, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // One clock: drive inputs, check ready at negedge, step model, check registered outputs after edge.
   task automatic do_cycle(input bit v, input int q, input int tag, input int rel);
      bit rdy;
      req_valid = v; req_query = QW'(q); req_tag = TAG_W'(tag); release_doc = NUM_DOC'(rel);
      @(negedge clk);
      rdy = model_ready();
      last_rdy = req_ready;
      check("req_ready", req_ready, rdy);
      model_step(v, q, tag, rel, rdy);
      @(posedge clk);
      #1;
      req_valid = 1'b0; release_doc = '0;
      check("resp_valid", resp_valid, e_valid);
      if (e_valid) begin
         check("resp_status", resp_status, e_status);
         check("resp_doc", resp_doc, e_doc);
         check("resp_tag", resp_tag, e_tag);
      end
      check("busy", busy, model_busy());
      check("reject_cnt", reject_cnt, m_rej);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      bit v; int q; int tag; int rel;
      bit ev; logic [1:0] est; int edoc; logic [3:0] ebusy;
   } vec_t;
   vec_t tbl[7];

   task automatic apply_vec(input vec_t t, input int idx);
      do_cycle(t.v, t.q, t.tag, t.rel);
      check($sformatf("vec%0d_valid", idx), resp_valid, t.ev);
      if (t.ev) begin
         check($sformatf("vec%0d_status", idx), resp_status, t.est);
         check($sformatf("vec%0d_doc", idx), resp_doc, t.edoc);
      end
      check($sformatf("vec%0d_busy", idx), busy, t.ebusy);
   endtask

   task automatic fill_all();
      do_cycle(1, 2, 1, 0);
      do_cycle(1, 2, 2, 0);
      do_cycle(1, 2, 3, 0);
      do_cycle(1, 3, 4, 0);
      check("fill_busy", busy, 4'b1111);
   endtask

   initial begin
      tbl[0] = '{v:1, q:0, tag:3, rel:0,      ev:1, est:2'b01,   edoc:0, ebusy:4'b0001};
      tbl[1] = '{v:1, q:3, tag:1, rel:0,      ev:1, est:2'b01,   edoc:1, ebusy:4'b0010};
      tbl[2] = '{v:1, q:3, tag:2, rel:0,      ev:1, est:2'b01,   edoc:2, ebusy:4'b0110};
      tbl[3] = '{v:1, q:3, tag:3, rel:0,      ev:1, est:2'b01,   edoc:3, ebusy:4'b1110};
      tbl[4] = '{v:0, q:0, tag:0, rel:4'b0100, ev:0, est:2'b00,  edoc:0, ebusy:4'b1010};
      tbl[5] = '{v:1, q:0, tag:4, rel:0,      ev:1, est:2'b01,   edoc:0, ebusy:4'b1011};
      tbl[6] = '{v:1, q:0, tag:5, rel:0,      ev:1, est:2'b01,   edoc:2, ebusy:4'b1111};

      do_reset();

      // first assignment and full consultation length
      apply_vec(tbl[0], 0);
      check("first_tag", resp_tag, 3);
      repeat (14) do_cycle(0, 0, 0, 0);
      check("busy_held_15", busy, 4'b0001);
      do_cycle(0, 0, 0, 0);
      check("busy_expired", busy, 4'b0000);

      // capability priority, early release, reuse of released doctor
      for (int i = 1; i < 7; i++) apply_vec(tbl[i], i);

      // no eligible doctor
      do_cycle(1, 2, 6, 0);
      check("noelig_status", resp_status, NOELIG_ST);
      check("noelig_doc", resp_doc, 0);
`ifndef WAITQ_EN
      check("reject_one", reject_cnt, 1);
`endif

      // q0 flood: mostly no eligible doctor, saturating the reject counter
      for (int i = 0; i < 400; i++) do_cycle(1, 0, i & 15, 0);
`ifndef WAITQ_EN
      check("reject_saturate", reject_cnt, 255);
`endif

`ifdef WAITQ_EN
      // queue fill, back-pressure, dispatch on release
      do_reset();
      fill_all();
      for (int i = 0; i < 4; i++) begin
         do_cycle(1, 1, 8 + i, 0);
         check("enq_status", resp_status, 2);
      end
      do_cycle(1, 1, 12, 0);
      check("full_backpressure", last_rdy, 0);
      do_cycle(0, 0, 0, 4'b0010);
      check("release_no_resp", resp_valid, 0);
      do_cycle(0, 0, 0, 0);
      check("dispatch_status", resp_status, 1);
      check("dispatch_doc", resp_doc, 1);
      check("dispatch_tag", resp_tag, 8);
`endif

      // reset in the middle of activity
      do_reset();
      fill_all();
`ifdef WAITQ_EN
      do_cycle(1, 1, 9, 0);
      do_cycle(1, 1, 10, 0);
`endif
      do_reset();
      repeat (3) do_cycle(0, 0, 0, 0);
      check("post_reset_busy", busy, 0);

      // randomized traffic against the model
      for (int i = 0; i < 500; i++) begin
         int rel;
         rel = 0;
         for (int d = 0; d < NUM_DOC; d++) if ($urandom_range(7) == 0) rel |= (1 << d);
         do_cycle($urandom_range(1), $urandom_range(NQ - 1), $urandom_range(15), rel);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got 0 expected 1");
      $fatal(1);
   end
endmodule
